ltpi_gpio_pin_bridge: RTL and testbench

LTPI_GPIO_PIN_BRIDGE -- requirements
Module: ltpi_gpio_pin_bridge

---
 rtl/ltpi_gpio_pin_bridge_pkg.sv | 28 ++
 rtl/ltpi_gpio_debounce.sv | 49 ++++
 rtl/ltpi_gpio_pin_bridge.sv | 134 +++++++++++++
 tb/tb_ltpi_gpio_pin_bridge.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ltpi_gpio_pin_bridge_pkg.sv
// Shared types for the LTPI GPIO pin bridge: link FSM states and the change counter.
package ltpi_gpio_pin_bridge_pkg;

    localparam int unsigned COUNT_W = 16;

    typedef logic [COUNT_W-1:0] count_t;

    localparam count_t COUNT_MAX = '1;

    typedef enum logic [1:0] {
        LINK_DOWN = 2'd0,
        HOLDOFF   = 2'd1,
        LINK_UP   = 2'd2
    } link_state_t;

    // Saturating counter step; a clear coinciding with an increment yields 1.
    function automatic count_t count_next(input count_t cur, input logic inc, input logic clr);
        count_t nxt;
        nxt = cur;
        if (clr) begin
            nxt = inc ? COUNT_W'(1) : '0;
        end else if (inc && (cur != COUNT_MAX)) begin
            nxt = cur + COUNT_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ltpi_gpio_debounce.sv
// One input channel: metastability synchroniser followed by a stability-window debouncer.
module ltpi_gpio_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic stable
);

    localparam int unsigned CNT_W_RAW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam int unsigned CNT_LAST  = (DEBOUNCE_CYCLES == 0) ? 0 : DEBOUNCE_CYCLES - 1;

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   s;

    assign s = sync[SYNC_STAGES-1];

    // Shift the raw pin through the synchroniser chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pin};
        end
    end

    // Accept a new level only after it has differed for the full window; the counter stops at CNT_LAST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (DEBOUNCE_CYCLES == 0) begin
            cnt    <= '0;
            stable <= s;
        end else if (s == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(CNT_LAST)) begin
            cnt    <= '0;
            stable <= s;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ltpi_gpio_pin_bridge.sv
// Bridges board GPIO pins to/from the LTPI tunnel: debounced inputs, link-gated outputs.
module ltpi_gpio_pin_bridge
    import ltpi_gpio_pin_bridge_pkg::*;
#(
    parameter int unsigned       NUM_IN          = 16,
    parameter int unsigned       NUM_OUT         = 16,
    parameter int unsigned       SYNC_STAGES     = 2,
    parameter int unsigned       DEBOUNCE_CYCLES = 250,
    parameter int unsigned       ALIGN_HOLDOFF   = 1024,
    parameter logic [NUM_OUT-1:0] FAILSAFE_OUT   = '0
) (
    input  logic               CLK_25M_OSC_CPU_FPGA,
    input  logic               reset_in,
    input  logic [NUM_IN-1:0]  pin_in,
    output logic [NUM_IN-1:0]  gpio_to_ltpi,
    input  logic [NUM_OUT-1:0] gpio_from_ltpi,
    input  logic               aligned,
    output logic [NUM_OUT-1:0] pin_out,
    output logic               link_up,
    output logic               in_change,
    input  logic               clr_count,
    output count_t             change_count
);

    localparam int unsigned HO_W_RAW = $clog2(ALIGN_HOLDOFF);
    localparam int unsigned HO_W     = (HO_W_RAW < 1) ? 1 : HO_W_RAW;
    localparam int unsigned HO_LAST  = ALIGN_HOLDOFF - 1;

    logic clk;
    logic rst;

    assign clk = CLK_25M_OSC_CPU_FPGA;
    assign rst = reset_in;

    logic [NUM_IN-1:0] stable;
    logic [NUM_IN-1:0] stable_prev;

    link_state_t     state;
    link_state_t     state_next;
    logic [HO_W-1:0] ho_cnt;
    logic [HO_W-1:0] ho_cnt_next;

    // Per-channel synchroniser and debouncer.
    for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
        ltpi_gpio_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .rst    (rst),
            .pin    (pin_in[i]),
            .stable (stable[i])
        );
    end

    assign gpio_to_ltpi = stable;

    // Edge-detect the debounced vector; any number of simultaneous bit changes gives one pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_prev <= '0;
            in_change   <= 1'b0;
        end else begin
            stable_prev <= stable;
            in_change   <= |(stable ^ stable_prev);
        end
    end

    // Saturating count of change pulses with synchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            change_count <= '0;
        end else begin
            change_count <= count_next(change_count, in_change, clr_count);
        end
    end

    // Link FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= LINK_DOWN;
            ho_cnt <= '0;
        end else begin
            state  <= state_next;
            ho_cnt <= ho_cnt_next;
        end
    end

    // Link FSM next state: aligned must hold for the whole holdoff window before going live.
    always_comb begin
        state_next  = state;
        ho_cnt_next = ho_cnt;
        case (state)
            LINK_DOWN: begin
                if (aligned) begin
                    state_next  = HOLDOFF;
                    ho_cnt_next = '0;
                end
            end
            HOLDOFF: begin
                if (!aligned) begin
                    state_next  = LINK_DOWN;
                    ho_cnt_next = '0;
                end else if (ho_cnt == HO_W'(HO_LAST)) begin
                    state_next  = LINK_UP;
                    ho_cnt_next = '0;
                end else begin
                    ho_cnt_next = ho_cnt + HO_W'(1);
                end
            end
            LINK_UP: begin
                if (!aligned) begin
                    state_next = LINK_DOWN;
                end
            end
            default: begin
                state_next  = LINK_DOWN;
                ho_cnt_next = '0;
            end
        endcase
    end

    // Registered outputs: link_up tracks the state, pin_out follows one cycle behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            link_up <= 1'b0;
            pin_out <= FAILSAFE_OUT;
        end else begin
            link_up <= (state_next == LINK_UP);
            pin_out <= (state == LINK_UP) ? gpio_from_ltpi : FAILSAFE_OUT;
        end
    end

endmodule

// File: tb/tb_ltpi_gpio_pin_bridge.sv
// Directed bench for ltpi_gpio_pin_bridge with hand-computed expectations.
module tb_ltpi_gpio_pin_bridge;

    logic        clk = 1'b0;
    logic        reset_in;
    logic [3:0]  pin_in;
    logic [3:0]  gpio_to_ltpi;
    logic [3:0]  gpio_from_ltpi;
    logic        aligned;
    logic [3:0]  pin_out;
    logic        link_up;
    logic        in_change;
    logic        clr_count;
    logic [15:0] change_count;

    int total = 0;
    int bad   = 0;
    int pulses;

    always #20 clk = ~clk;

    ltpi_gpio_pin_bridge #(
        .NUM_IN          (4),
        .NUM_OUT         (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .ALIGN_HOLDOFF   (8),
        .FAILSAFE_OUT    (4'b1010)
    ) dut (
        .CLK_25M_OSC_CPU_FPGA (clk),
        .reset_in             (reset_in),
        .pin_in               (pin_in),
        .gpio_to_ltpi         (gpio_to_ltpi),
        .gpio_from_ltpi       (gpio_from_ltpi),
        .aligned              (aligned),
        .pin_out              (pin_out),
        .link_up              (link_up),
        .in_change            (in_change),
        .clr_count            (clr_count),
        .change_count         (change_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_in       = 1'b1;
        pin_in         = 4'b0000;
        gpio_from_ltpi = 4'b0000;
        aligned        = 1'b0;
        clr_count      = 1'b0;
        steps(3);
        reset_in = 1'b0;

        // reset state
        check("rst_gpio",    16'(gpio_to_ltpi), 16'h0000);
        check("rst_pin_out", 16'(pin_out),      16'h000A);
        check("rst_link_up", 16'(link_up),      16'h0000);
        check("rst_in_chg",  16'(in_change),    16'h0000);
        check("rst_count",   change_count,      16'h0000);

        // held rise on pin 0: visible exactly 6 cycles later
        pin_in = 4'b0001;
        steps(5);
        check("deb_lat5", 16'(gpio_to_ltpi), 16'h0000);
        step();
        check("deb_lat6", 16'(gpio_to_ltpi), 16'h0001);
        check("deb_chg6", 16'(in_change),    16'h0000);
        step();
        check("deb_chg7", 16'(in_change),    16'h0001);
        check("deb_cnt7", change_count,      16'h0000);
        step();
        check("deb_chg8", 16'(in_change),    16'h0000);
        check("deb_cnt8", change_count,      16'h0001);

        // 3-cycle glitch on pin 1 is rejected
        pin_in = 4'b0011;
        steps(3);
        pin_in = 4'b0001;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (in_change) pulses++;
        end
        check("glitch_gpio",   16'(gpio_to_ltpi), 16'h0001);
        check("glitch_pulses", 16'(pulses),       16'h0000);
        check("glitch_count",  change_count,      16'h0001);

        // holdoff: 8 cycles failsafe, then link_up, pin_out live one cycle later
        gpio_from_ltpi = 4'b0101;
        aligned        = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("ho_link_up", 16'(link_up), 16'h0000);
            check("ho_pin_out", 16'(pin_out), 16'h000A);
        end
        step();
        check("up_link_up",  16'(link_up), 16'h0001);
        check("up_pin_out9", 16'(pin_out), 16'h000A);
        step();
        check("up_pin_out10", 16'(pin_out), 16'h0005);

        // first aligned=0 drops the link
        aligned = 1'b0;
        step();
        check("drop_link_up", 16'(link_up), 16'h0000);
        check("drop_pin_d1",  16'(pin_out), 16'h0005);
        step();
        check("drop_pin_d2",  16'(pin_out), 16'h000A);

        // one-cycle dropout inside holdoff restarts the full window
        aligned = 1'b1;
        steps(5);
        aligned = 1'b0;
        step();
        aligned = 1'b1;
        steps(8);
        check("reho_link_8", 16'(link_up), 16'h0000);
        step();
        check("reho_link_9", 16'(link_up), 16'h0001);
        gpio_from_ltpi = 4'b0011;
        step();
        check("live_pin_out", 16'(pin_out), 16'h0003);

        // saturation and clear priority
        force dut.change_count = 16'hFFFF;
        step();
        release dut.change_count;
        step();
        check("sat_forced", change_count, 16'hFFFF);
        pin_in = 4'b0000;
        steps(7);
        check("sat_chg",  16'(in_change), 16'h0001);
        step();
        check("sat_hold", change_count,   16'hFFFF);
        pin_in = 4'b0001;
        steps(7);
        check("clr_chg", 16'(in_change), 16'h0001);
        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        check("clr_coincide", change_count, 16'h0001);
        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        check("clr_only", change_count, 16'h0000);

        // async reset while LINK_UP and mid-debounce on pin 2
        pin_in = 4'b0101;
        steps(3);
        #3;
        reset_in = 1'b1;
        #1;
        check("arst_pin_out", 16'(pin_out),      16'h000A);
        check("arst_link_up", 16'(link_up),      16'h0000);
        check("arst_count",   change_count,      16'h0000);
        check("arst_gpio",    16'(gpio_to_ltpi), 16'h0000);
        check("arst_in_chg",  16'(in_change),    16'h0000);
        step();
        reset_in = 1'b0;

        // full debounce and holdoff windows restart after release
        steps(5);
        check("rst_deb5", 16'(gpio_to_ltpi), 16'h0000);
        step();
        check("rst_deb6", 16'(gpio_to_ltpi), 16'h0005);
        steps(2);
        check("rst_ho8",    16'(link_up),    16'h0000);
        check("rst_cnt_8",  change_count,    16'h0001);
        step();
        check("rst_ho9",    16'(link_up),    16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
